// File: rtl/core_mem_arbiter_if.sv
// Bundle of the IF, LS and memory-side signals around core_mem_arbiter.
// The arbiter connects through 'slave'; the core/memory environment through 'master'.
interface core_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_in;
  logic [ADDR_W-1:0] if_addr_in;
  logic [DATA_W-1:0] if_rdata_out;
  logic              if_ack_out;

  logic              ls_req_in;
  logic              ls_rw_in;
  logic [ADDR_W-1:0] ls_addr_in;
  logic [DATA_W-1:0] ls_wdata_in;
  logic [DATA_W-1:0] ls_rdata_out;
  logic              ls_ack_out;

  logic              mem_req_out;
  logic              mem_rw_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [DATA_W-1:0] mem_wdata_out;
  logic [DATA_W-1:0] mem_rdata_in;
  logic              mem_ack_in;

  logic              stall_out;
  logic              err_out;

  modport slave (
    input  if_req_in, if_addr_in,
    input  ls_req_in, ls_rw_in, ls_addr_in, ls_wdata_in,
    input  mem_rdata_in, mem_ack_in,
    output if_rdata_out, if_ack_out,
    output ls_rdata_out, ls_ack_out,
    output mem_req_out, mem_rw_out, mem_addr_out, mem_wdata_out,
    output stall_out, err_out
  );

  modport master (
    output if_req_in, if_addr_in,
    output ls_req_in, ls_rw_in, ls_addr_in, ls_wdata_in,
    output mem_rdata_in, mem_ack_in,
    input  if_rdata_out, if_ack_out,
    input  ls_rdata_out, ls_ack_out,
    input  mem_req_out, mem_rw_out, mem_addr_out, mem_wdata_out,
    input  stall_out, err_out
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// Shares the core memory port between instruction fetch and load/store, with a hung-access watchdog.
// Define CORE_ARB_RR_EN for round-robin on simultaneous requests; default is fixed LS > IF priority.
module core_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  core_mem_arbiter_if.slave  bus
);

  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, IF_BUSY, LS_BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] wd_cnt;
  logic             grant_ls;
  logic             timeout;

`ifdef CORE_ARB_RR_EN
  // rr_ls set means LS wins the next tie; it flips to whoever was not just served.
  logic rr_ls;

  assign grant_ls = bus.ls_req_in & (~bus.if_req_in | rr_ls);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                rr_ls <= 1'b1;
    else if (state == DONE)  rr_ls <= bus.if_ack_out;
  end
`else
  assign grant_ls = bus.ls_req_in;
`endif

  // The abort fires on the last allowed busy cycle only if the memory stays silent.
  assign timeout = WD_EN && (wd_cnt == CNT_LAST) && !bus.mem_ack_in;

  assign bus.stall_out = (bus.if_req_in & ~bus.if_ack_out) |
                         (bus.ls_req_in & ~bus.ls_ack_out);

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      wd_cnt            <= '0;
      bus.mem_req_out   <= 1'b0;
      bus.mem_rw_out    <= 1'b0;
      bus.mem_addr_out  <= {ADDR_W{1'b0}};
      bus.mem_wdata_out <= {DATA_W{1'b0}};
      bus.if_rdata_out  <= {DATA_W{1'b0}};
      bus.ls_rdata_out  <= {DATA_W{1'b0}};
      bus.if_ack_out    <= 1'b0;
      bus.ls_ack_out    <= 1'b0;
      bus.err_out       <= 1'b0;
    end else begin
      bus.if_ack_out <= 1'b0;
      bus.ls_ack_out <= 1'b0;
      bus.err_out    <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.ls_req_in || bus.if_req_in) begin
            wd_cnt          <= '0;
            bus.mem_req_out <= 1'b1;
            if (grant_ls) begin
              bus.mem_rw_out    <= bus.ls_rw_in;
              bus.mem_addr_out  <= bus.ls_addr_in;
              bus.mem_wdata_out <= bus.ls_wdata_in;
              state             <= LS_BUSY;
            end else begin
              bus.mem_rw_out    <= 1'b0;
              bus.mem_addr_out  <= bus.if_addr_in;
              state             <= IF_BUSY;
            end
          end
        end

        IF_BUSY, LS_BUSY: begin
          if (bus.mem_ack_in || timeout) begin
            bus.mem_req_out <= 1'b0;
            bus.err_out     <= !bus.mem_ack_in;
            state           <= DONE;
            if (state == IF_BUSY) begin
              bus.if_ack_out   <= 1'b1;
              bus.if_rdata_out <= bus.mem_ack_in ? bus.mem_rdata_in : {DATA_W{1'b0}};
            end else begin
              bus.ls_ack_out <= 1'b1;
              // A completed write leaves the LS read data untouched.
              if (!bus.mem_ack_in)      bus.ls_rdata_out <= {DATA_W{1'b0}};
              else if (!bus.mem_rw_out) bus.ls_rdata_out <= bus.mem_rdata_in;
            end
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: a memory model predicts each response at grant time,
// and an independent monitor pops and compares on every requester ack.
module tb_core_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  core_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  core_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t          if_q[$];
  exp_t          ls_q[$];
  logic [DW-1:0] ram [logic [AW-1:0]];
  logic [DW-1:0] ref_if_rdata = '0;
  logic [DW-1:0] ref_ls_rdata = '0;
  logic          ref_last_ls  = 1'b0;
  logic [AW-1:0] cur_if_addr  = '0;
  logic [AW-1:0] cur_ls_addr  = '0;
  logic          cur_ls_rw    = 1'b0;
  logic [DW-1:0] cur_ls_wdata = '0;
  logic          smp_if = 1'b0;
  logic          smp_ls = 1'b0;
  int            force_lat = -1;
  bit            rand_phase = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ram_read(input logic [AW-1:0] a);
    if (!ram.exists(a)) ram[a] = $urandom;
    return ram[a];
  endfunction

  // Request lines as the arbiter saw them on the last rising edge.
  always @(posedge clk) begin
    smp_if <= bus.if_req_in;
    smp_ls <= bus.ls_req_in;
  end

  // Memory model: decides latency per access, predicts the requester's response.
  initial begin : mem_model
    bit            active;
    bit            who_ls;
    int            k;
    int            lat;
    logic [AW-1:0] ea;
    logic          erw;
    logic [DW-1:0] ewd;
    logic [DW-1:0] rd;
    exp_t          e;
    active = 1'b0; who_ls = 1'b0; k = 0; lat = 0;
    bus.mem_ack_in   = 1'b0;
    bus.mem_rdata_in = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack_in   = 1'b0;
      bus.mem_rdata_in = $urandom;
      if (!rst) begin
        active = 1'b0;
      end else if (bus.mem_req_out) begin
        if (!active) begin
          active = 1'b1;
          k      = 0;
          check("grant_has_req", smp_if | smp_ls, 1);
`ifdef CORE_ARB_RR_EN
          who_ls = smp_ls && (!smp_if || !ref_last_ls);
`else
          who_ls = smp_ls;
`endif
          ea  = who_ls ? cur_ls_addr : cur_if_addr;
          erw = who_ls ? cur_ls_rw : 1'b0;
          ewd = cur_ls_wdata;
          check("mem_addr", bus.mem_addr_out, ea);
          check("mem_rw", bus.mem_rw_out, erw);
          if (erw) check("mem_wdata", bus.mem_wdata_out, ewd);
          if (force_lat >= 0) lat = force_lat;
          else begin
            lat = $urandom_range(0, 4);
            if (lat == 4) lat = 99;
          end
          rd = ram_read(ea);
          if (lat >= TO) begin
            e.rdata = '0;
            e.err   = 1'b1;
          end else begin
            e.err   = 1'b0;
            e.rdata = erw ? (who_ls ? ref_ls_rdata : ref_if_rdata) : rd;
          end
          if (who_ls) begin ref_ls_rdata = e.rdata; ls_q.push_back(e); end
          else        begin ref_if_rdata = e.rdata; if_q.push_back(e); end
        end else begin
          k++;
          check("mem_hold_addr", bus.mem_addr_out, ea);
          check("mem_hold_rw", bus.mem_rw_out, erw);
          if (erw) check("mem_hold_wdata", bus.mem_wdata_out, ewd);
          check("mem_req_within_timeout", k < TO, 1);
        end
        if (k == lat) begin
          bus.mem_ack_in   = 1'b1;
          bus.mem_rdata_in = erw ? $urandom : rd;
          if (erw) ram[ea] = ewd;
        end
      end else if (active) begin
        active = 1'b0;
        check("mem_req_cycles", k + 1, (lat < TO) ? lat + 1 : TO);
        check("ack_after_req_drop", who_ls ? bus.ls_ack_out : bus.if_ack_out, 1);
        ref_last_ls = who_ls;
      end else if (rand_phase && $urandom_range(0, 5) == 0) begin
        bus.mem_ack_in = 1'b1;
      end
    end
  end

  // Monitor: pops the predicted response whenever a requester ack appears.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("ack_exclusive", bus.if_ack_out & bus.ls_ack_out, 0);
        check("stall", bus.stall_out,
              (bus.if_req_in & ~bus.if_ack_out) | (bus.ls_req_in & ~bus.ls_ack_out));
        if (bus.if_ack_out) begin
          check("if_ack_pending", if_q.size() != 0, 1);
          if (if_q.size() != 0) begin
            e = if_q.pop_front();
            check("if_rdata", bus.if_rdata_out, e.rdata);
            check("if_err", bus.err_out, e.err);
          end
        end
        if (bus.ls_ack_out) begin
          check("ls_ack_pending", ls_q.size() != 0, 1);
          if (ls_q.size() != 0) begin
            e = ls_q.pop_front();
            check("ls_rdata", bus.ls_rdata_out, e.rdata);
            check("ls_err", bus.err_out, e.err);
          end
        end
        if (!bus.if_ack_out && !bus.ls_ack_out) check("err_idle", bus.err_out, 0);
      end
    end
  end

  task automatic do_if(input logic [AW-1:0] addr);
    int n = 0;
    @(posedge clk); #1;
    cur_if_addr    = addr;
    bus.if_addr_in = addr;
    bus.if_req_in  = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.if_ack_out && n < 60);
    check("if_done_in_time", bus.if_ack_out, 1);
    @(posedge clk); #1;
    bus.if_req_in = 1'b0;
  endtask

  task automatic do_ls(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int n = 0;
    @(posedge clk); #1;
    cur_ls_addr     = addr;
    cur_ls_rw       = rw;
    cur_ls_wdata    = wdata;
    bus.ls_addr_in  = addr;
    bus.ls_rw_in    = rw;
    bus.ls_wdata_in = wdata;
    bus.ls_req_in   = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.ls_ack_out && n < 60);
    check("ls_done_in_time", bus.ls_ack_out, 1);
    @(posedge clk); #1;
    bus.ls_req_in = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_req"}, bus.mem_req_out, 0);
    check({tag, "_mem_rw"}, bus.mem_rw_out, 0);
    check({tag, "_mem_addr"}, bus.mem_addr_out, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata_out, 0);
    check({tag, "_if_ack"}, bus.if_ack_out, 0);
    check({tag, "_ls_ack"}, bus.ls_ack_out, 0);
    check({tag, "_if_rdata"}, bus.if_rdata_out, 0);
    check({tag, "_ls_rdata"}, bus.ls_rdata_out, 0);
    check({tag, "_err"}, bus.err_out, 0);
  endtask

  initial begin : watchdog
    #400_000;
    $display("FAIL global_timeout: simulation still running at t=%0t", $time);
    $fatal(1, "bench did not finish in time");
  end

  initial begin : main
    int n;
    bus.if_req_in   = 1'b0;
    bus.if_addr_in  = '0;
    bus.ls_req_in   = 1'b0;
    bus.ls_rw_in    = 1'b0;
    bus.ls_addr_in  = '0;
    bus.ls_wdata_in = '0;

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    check("reset_stall", bus.stall_out, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Single IF read, memory acks two cycles into the request.
    ram[32'h10] = 32'hDEAD_BEEF;
    force_lat = 2;
    do_if(32'h10);

    // LS write leaves ls_rdata untouched.
    force_lat = 1;
    do_ls(1'b1, 32'h100, 32'h1234_5678);

    // Simultaneous requests with zero-wait memory.
    force_lat = 0;
    repeat (2) fork do_if(32'h20); do_ls(1'b0, 32'h100, '0); join
    do_ls(1'b0, 32'h104, '0);
    fork do_if(32'h24); do_ls(1'b1, 32'h108, 32'hA5A5_0001); join
    fork do_if(32'h28); do_ls(1'b0, 32'h108, '0); join

    // Watchdog abort, then ack on the last allowed cycle.
    force_lat = 99;
    do_if(32'h30);
    do_ls(1'b0, 32'h100, '0);
    force_lat = TO - 1;
    do_if(32'h10);
    do_ls(1'b0, 32'h100, '0);

    // Asynchronous reset while LS_BUSY.
    force_lat = 99;
    @(posedge clk); #1;
    cur_ls_addr     = 32'h200;
    cur_ls_rw       = 1'b0;
    bus.ls_addr_in  = 32'h200;
    bus.ls_rw_in    = 1'b0;
    bus.ls_req_in   = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.mem_req_out && n < 10);
    check("rst_test_busy", bus.mem_req_out, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("rst_async_mem_req", bus.mem_req_out, 0);
    if_q.delete();
    ls_q.delete();
    ref_if_rdata = '0;
    ref_ls_rdata = '0;
    ref_last_ls  = 1'b0;
    bus.ls_req_in = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("rst_mid");
    @(posedge clk); #1 rst = 1'b1;
    force_lat = 0;
    do_if(32'h10);

    // Randomized traffic on both requesters, with stray memory acks.
    force_lat  = -1;
    rand_phase = 1'b1;
    fork
      begin
        logic [AW-1:0] ia;
        repeat (150) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          ia = AW'($urandom_range(0, 15)) << 2;
          do_if(ia);
        end
      end
      begin
        logic [AW-1:0] la;
        logic          lrw;
        repeat (150) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          la  = AW'($urandom_range(0, 15)) << 2;
          lrw = 1'($urandom_range(0, 1));
          do_ls(lrw, la, $urandom);
        end
      end
    join
    rand_phase = 1'b0;

    repeat (5) @(negedge clk);
    check("if_q_drained", if_q.size(), 0);
    check("ls_q_drained", ls_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
